// File: rtl/key_debounce.sv
// key_debounce: per-key two-flop synchronizer plus stable-count debouncer with registered edge pulses.
// Define KEY_DEBOUNCE_RELEASE_EN to build release-edge pulses; otherwise release_pulse is tied to 0.
module key_debounce #(
  parameter int WIDTH = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, accept;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          level;
    // Counting only while sync2 disagrees with the accepted level; clearing on acceptance bounds cnt.
    assign accept[i] = (sync2[i] != level) && (cnt == LAST);
    assign key_out[i] = level;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt   <= '0;
        level <= 1'b1;
      end else begin
        cnt   <= (sync2[i] == level || accept[i]) ? '0 : cnt + 1'b1;
        level <= accept[i] ? sync2[i] : level;
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) press_pulse <= '0;
    else press_pulse <= accept & ~sync2;
`ifdef KEY_DEBOUNCE_RELEASE_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) release_pulse <= '0;
    else release_pulse <= accept & sync2;
`else
  assign release_pulse = '0;
`endif
endmodule
